// File: rtl/deserializador32_pkg.sv
// Shared definitions for the deserializador32 receiver and its stimulus:
// FSM state encoding, upstream shift-register mode codes and direction codes.
package deserializador32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Mode codes of the upstream 32-bit shift register (MODO input).
    typedef enum logic [1:0] {
        MODO_SHIFT  = 2'b00,
        MODO_ROTATE = 2'b01,
        MODO_LOAD   = 2'b10
    } modo_t;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

endpackage

// File: rtl/deserializador32_contador_bits.sv
// Bit counter for the receiver: synchronous clear, count enable and a
// terminal flag raised while the count equals WIDTH-1 (last bit of a frame).
module contador_bits
    import deserializador32_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        // NOTE: assign a default first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (count_q == TERM_VAL);

endmodule

// File: rtl/deserializador32.sv
// Serial-to-parallel receiver behind the 32-bit shift register: rebuilds one
// word per frame in the latched direction, offers it with VALID/READY and
// raises a sticky OVERRUN when a completed word cannot be delivered.
module deserializador32
    import deserializador32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic             START,
    input  logic             READY,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             BUSY,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVERRUN
);

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;

    logic [WIDTH-1:0]   shadow_next;
    logic               sample;
    logic               complete;
    logic               cnt_term;

    // Capture datapath: the shadow word with this cycle's bit inserted.
    always_comb begin
        sample      = (state_q == ST_SHIFT) && ENB;
        complete    = sample && cnt_term;
        shadow_next = dir_q ? {shadow_q[WIDTH-2:0], S_IN}
                            : {S_IN, shadow_q[WIDTH-1:1]};
    end

    // FSM next state: START (re)opens a frame after any completion is taken.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        shadow_d = shadow_q;
        if (START) begin
            state_d  = ST_SHIFT;
            dir_d    = DIR;
            shadow_d = '0;
        end else if (complete) begin
            state_d  = ST_IDLE;
            shadow_d = '0;
        end else if (sample) begin
            shadow_d = shadow_next;
        end
    end

    // Output word and handshake: deliver, replace on same-edge READY, or drop.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (complete) begin
            if (!valid_q || READY) begin
                q_d     = shadow_next;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end
    end

    // State, shadow, output and flag registers.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_MSB_FIRST;
            shadow_q <= '0;
            q_q      <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            shadow_q <= shadow_d;
            q_q      <= q_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    contador_bits #(
        .CNT_W (CNT_W),
        .WIDTH (WIDTH)
    ) u_contador (
        .clk   (CLK),
        .rst_n (RESET_L),
        .clr   (START || complete),
        .en    (sample),
        .count (COUNT),
        .term  (cnt_term)
    );

    assign Q       = q_q;
    assign VALID   = valid_q;
    assign BUSY    = (state_q == ST_SHIFT);
    assign OVERRUN = ovr_q;

endmodule

// File: doc/deserializador32.md
Name: deserializador32

Overview:
- Serial-to-parallel receiver that sits directly downstream of the 32-bit shift register and consumes its serial output (S_OUT32).
- Reassembles one 32-bit word per frame, honouring the shift direction in use, and presents it with a VALID/READY handshake to the next stage.
- Flags overrun when a completed word cannot be delivered.

Parameters:
- WIDTH, 32, word length in bits; frame length equals WIDTH.
- CNT_W, 6, bit-counter width; must hold the value WIDTH.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET_L  input  1  asynchronous, active-low reset.
- ENB  input  1  sample enable; same signal that drives the shift register's ENB32.
- DIR  input  1  shift direction of the upstream register (1 = MSB out first, 0 = LSB out first); latched at START.
- S_IN  input  1  serial data; connects to S_OUT32.
- START  input  1  frame start strobe, issued in the same cycle as the upstream parallel load.
- READY  input  1  downstream consumer accepts Q this cycle.
- Q  output  WIDTH  reassembled word.
- VALID  output  1  Q holds an undelivered word.
- BUSY  output  1  frame capture in progress.
- COUNT  output  CNT_W  bits captured in the current frame.
- OVERRUN  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset is asynchronous and active-low on RESET_L, with a single clock CLK. While RESET_L=0:
  - Q=0, VALID=0, BUSY=0, COUNT=0, OVERRUN=0.
  - State=IDLE; shadow register=0; latched direction=1.
  - Reset asserted mid-frame discards the partial word with no other effect.
- States:
  - IDLE: BUSY=0. START=1 at an edge -> SHIFT, COUNT<=0, dir_l<=DIR, shadow<=0. ENB is not required for START.
  - SHIFT: BUSY=1. At each edge with ENB=1 one S_IN bit is captured and COUNT increments. ENB=0 stalls: no sample, COUNT held.
- Bit placement:
  - dir_l=1: shadow <= {shadow[WIDTH-2:0], S_IN}, so the first bit lands in the MSB.
  - dir_l=0: shadow <= {S_IN, shadow[WIDTH-1:1]}, so the first bit lands in the LSB.
- Timing: START sampled at edge n; data sampled at edges n+1 … n+WIDTH when ENB=1 throughout.
- Frame completion: on the edge capturing bit WIDTH (COUNT would reach WIDTH):
  - The word, including that bit, is delivered to Q.
  - State -> IDLE; COUNT <= 0.
  - VALID is visible in the cycle after edge n+WIDTH.
- Handshake:
  - VALID stays 1 until an edge with VALID=1 and READY=1; that edge clears VALID.
  - Q holds its value while VALID=1 and is not altered by READY.
- Boundary cases:
  - Completion with VALID=0: Q<=word, VALID<=1.
  - Completion with VALID=1 and READY=1 at the same edge: Q<=new word, VALID stays 1, no overrun.
  - Completion with VALID=1 and READY=0: new word dropped, Q unchanged, OVERRUN<=1. OVERRUN clears only on reset.
  - START while in SHIFT: restart. Partial word discarded, COUNT<=0, dir_l re-latched, no sample at that edge.
  - START at the completion edge: completion takes priority for delivery, and the block then enters SHIFT for the new frame.
  - DIR changes mid-frame are ignored (dir_l used).
  - S_IN and READY are don't-care in IDLE, apart from the handshake.
- Widths: COUNT compares against WIDTH in CNT_W bits with no wrap. COUNT never exceeds WIDTH-1 as a visible value.

Decomposition:
- Shared include file defs_desp.v holds:
  - State encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Register mode codes used by the shift register and its stimulus (MODO shift/rotate/load).
  - DIR_MSB_FIRST=1, DIR_LSB_FIRST=0.
- One sub-module: contador_bits. It is a CNT_W-bit counter with sync clear, enable and a terminal flag at WIDTH-1. It is instantiated once for COUNT.
- FSM, shadow register, output register and handshake live in deserializador32.

Test Plan:
- MSB-first frame: DIR=1, START, ENB=1, serialise 0xA5C3_0F1E MSB first -> VALID=1 at cycle n+32, Q=0xA5C3_0F1E, COUNT back to 0.
- LSB-first frame with stalls: DIR=0, serialise 0x1234_5678 LSB first, ENB low on 5 random cycles -> Q=0x1234_5678, VALID delayed by exactly 5 cycles, COUNT frozen during each stall.
- Back-to-back with READY=1 at completion: two frames 0xFFFF_0000 then 0x0000_FFFF -> Q updates to the second word, VALID continuous, OVERRUN=0.
- Overrun: first frame delivered, READY held 0, second frame 0xDEAD_BEEF completes -> Q keeps the first word, OVERRUN=1 and stays 1 after a later READY.
- Restart and reset: START again after 10 bits -> the next 32 bits form Q. Separately, RESET_L=0 at bit 20 -> all outputs 0 immediately (asynchronously), and a subsequent frame captures correctly.
- Loopback with the shift register: MODO=load 0x8000_0001 then shift, S_OUT32 -> S_IN, for both DIR values -> Q equals the loaded word, checked by the verifier with no ALERTA.
